// File: rtl/prv_trap_pkg.sv
// prv_trap_pkg
// Shared definitions for the trap controller: exc_req bit positions,
// mcause codes for exceptions and interrupts, the external interrupt
// cause base and the sequencer state type.
package prv_trap_pkg;

    localparam int EXC_W   = 9;
    localparam int CAUSE_W = 5;

    // exc_req bit positions
    localparam int EXC_MAL_INSN   = 0;
    localparam int EXC_FAULT_INSN = 1;
    localparam int EXC_ILLEGAL    = 2;
    localparam int EXC_BREAKPOINT = 3;
    localparam int EXC_MAL_LOAD   = 4;
    localparam int EXC_FAULT_LOAD = 5;
    localparam int EXC_MAL_STORE  = 6;
    localparam int EXC_FAULT_STORE = 7;
    localparam int EXC_ENV_M      = 8;

    // exception cause codes
    localparam logic [CAUSE_W-1:0] CAUSE_MAL_INSN    = 5'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_FAULT_INSN  = 5'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL     = 5'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT  = 5'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_MAL_LOAD    = 5'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_FAULT_LOAD  = 5'd5;
    localparam logic [CAUSE_W-1:0] CAUSE_MAL_STORE   = 5'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_FAULT_STORE = 5'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_ENV_M       = 5'd11;

    // interrupt cause codes
    localparam logic [CAUSE_W-1:0] CAUSE_M_SOFT      = 5'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_M_TIMER     = 5'd7;
    localparam logic [CAUSE_W-1:0] EXT_CAUSE_BASE    = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2,
        ST_RET   = 2'd3
    } trap_state_t;

endpackage

// File: rtl/prv_trap_prio_enc.sv
// prv_trap_prio_enc
// Combinational trap priority encoder. Any exception beats any interrupt.
//   exc_req    [EXC_W-1:0]        exception flags (see prv_trap_pkg bit map)
//   int_elig   [NUM_EXT_INT+1:0]  masked interrupt sources: bit0 timer,
//                                 bit1 soft, bit2+i external channel i
//   mie_global                    global interrupt enable
//   valid                         a trap should be taken
//   is_intr                       the winning trap is an interrupt
//   cause      [CAUSE_W-1:0]      cause code of the winner
module prv_trap_prio_enc
    import prv_trap_pkg::*;
#(
    parameter int NUM_EXT_INT = 4
) (
    input  logic [EXC_W-1:0]       exc_req,
    input  logic [NUM_EXT_INT+1:0] int_elig,
    input  logic                   mie_global,
    output logic                   valid,
    output logic                   is_intr,
    output logic [CAUSE_W-1:0]     cause
);

    logic               int_hit;
    logic [CAUSE_W-1:0] int_cause;
    logic               exc_hit;
    logic [CAUSE_W-1:0] exc_cause;

    // Lowest priority assigned first so higher-priority sources overwrite it;
    // the external loop runs downward so the lowest channel index wins.
    always_comb begin
        int_hit   = 1'b0;
        int_cause = '0;
        if (int_elig[0]) begin
            int_hit   = 1'b1;
            int_cause = CAUSE_M_TIMER;
        end
        if (int_elig[1]) begin
            int_hit   = 1'b1;
            int_cause = CAUSE_M_SOFT;
        end
        for (int i = NUM_EXT_INT - 1; i >= 0; i--) begin
            if (int_elig[i+2]) begin
                int_hit   = 1'b1;
                int_cause = EXT_CAUSE_BASE + CAUSE_W'(i);
            end
        end
    end

    always_comb begin
        exc_hit   = |exc_req;
        exc_cause = '0;
        if (exc_req[EXC_BREAKPOINT])       exc_cause = CAUSE_BREAKPOINT;
        else if (exc_req[EXC_FAULT_INSN])  exc_cause = CAUSE_FAULT_INSN;
        else if (exc_req[EXC_MAL_INSN])    exc_cause = CAUSE_MAL_INSN;
        else if (exc_req[EXC_ILLEGAL])     exc_cause = CAUSE_ILLEGAL;
        else if (exc_req[EXC_ENV_M])       exc_cause = CAUSE_ENV_M;
        else if (exc_req[EXC_MAL_LOAD])    exc_cause = CAUSE_MAL_LOAD;
        else if (exc_req[EXC_FAULT_LOAD])  exc_cause = CAUSE_FAULT_LOAD;
        else if (exc_req[EXC_MAL_STORE])   exc_cause = CAUSE_MAL_STORE;
        else if (exc_req[EXC_FAULT_STORE]) exc_cause = CAUSE_FAULT_STORE;
    end

    assign valid   = exc_hit | (mie_global & int_hit);
    assign is_intr = ~exc_hit & mie_global & int_hit;
    assign cause   = exc_hit ? exc_cause : int_cause;

endmodule

// File: rtl/prv_trap_controller.sv
// prv_trap_controller
// Trap sequencer: prioritises exceptions and interrupts, latches external
// interrupt pending state and walks flush -> redirect + CSR update, or
// performs an mret redirect. All outputs are registered.
//
// Build option: PRV_VECTORED_TRAP_EN enables vectored mtvec mode
// (mtvec[1:0] == 2'b01) for interrupts; without it priv_pc is always base.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   exc_req, epc, badaddr exception flags, faulting PC and address
//   ret, pipe_clear       mret committed, pipeline drained
//   timer_int, soft_int, ext_int, ext_claim   interrupt sources / claims
//   mie_global, mie_mask  global and per-source enables
//   mtvec, mepc_r         trap base/mode, current mepc
//   flush_req, insert_pc, priv_pc, intr        pipeline control
//   csr_we, mcause_w, mepc_w, mtval_w          CSR write port
//   mie_clr, mie_restore  mstatus MIE/MPIE handling
//   ext_pending           external pending register
//
// state  | meaning
// IDLE   | sampling exc_req / interrupts / ret
// FLUSH  | flush_req high, waiting for pipe_clear
// TRAP   | one cycle: redirect to trap target, write CSRs, clear MIE
// RET    | one cycle: redirect to mepc, restore MIE
module prv_trap_controller
    import prv_trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_EXT_INT = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [EXC_W-1:0]       exc_req,
    input  logic [XLEN-1:0]        epc,
    input  logic [XLEN-1:0]        badaddr,
    input  logic                   ret,
    input  logic                   pipe_clear,
    input  logic                   timer_int,
    input  logic                   soft_int,
    input  logic [NUM_EXT_INT-1:0] ext_int,
    input  logic [NUM_EXT_INT-1:0] ext_claim,
    input  logic                   mie_global,
    input  logic [NUM_EXT_INT+1:0] mie_mask,
    input  logic [XLEN-1:0]        mtvec,
    input  logic [XLEN-1:0]        mepc_r,
    output logic                   flush_req,
    output logic                   insert_pc,
    output logic [XLEN-1:0]        priv_pc,
    output logic                   intr,
    output logic                   csr_we,
    output logic [XLEN-1:0]        mcause_w,
    output logic [XLEN-1:0]        mepc_w,
    output logic [XLEN-1:0]        mtval_w,
    output logic                   mie_clr,
    output logic                   mie_restore,
    output logic [NUM_EXT_INT-1:0] ext_pending
);

    trap_state_t            state;
    logic [NUM_EXT_INT-1:0] pend_q;
    logic [CAUSE_W-1:0]     cause_q;
    logic                   intr_q;
    logic [XLEN-1:0]        epc_q;
    logic [XLEN-1:0]        mtval_q;

    logic [NUM_EXT_INT+1:0] int_elig;
    logic                   req_valid;
    logic                   req_intr;
    logic [CAUSE_W-1:0]     req_cause;
    logic                   mtval_zero;
    logic [XLEN-1:0]        trap_base;
    logic [XLEN-1:0]        trap_target;

    assign ext_pending = pend_q;
    assign int_elig    = mie_mask & {pend_q, soft_int, timer_int};

    prv_trap_prio_enc #(
        .NUM_EXT_INT (NUM_EXT_INT)
    ) u_prio_enc (
        .exc_req    (exc_req),
        .int_elig   (int_elig),
        .mie_global (mie_global),
        .valid      (req_valid),
        .is_intr    (req_intr),
        .cause      (req_cause)
    );

    // Interrupts and these three exceptions carry no address in mtval.
    assign mtval_zero = req_intr
                      | (req_cause == CAUSE_ILLEGAL)
                      | (req_cause == CAUSE_BREAKPOINT)
                      | (req_cause == CAUSE_ENV_M);

    // Masking (rather than slicing) keeps the mode bits referenced in both builds.
    assign trap_base = mtvec & {{(XLEN-2){1'b1}}, 2'b00};

`ifdef PRV_VECTORED_TRAP_EN
    assign trap_target = (intr_q && (mtvec[1:0] == 2'b01))
                       ? trap_base + XLEN'({cause_q, 2'b00})
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            pend_q      <= '0;
            cause_q     <= '0;
            intr_q      <= 1'b0;
            epc_q       <= '0;
            mtval_q     <= '0;
            flush_req   <= 1'b0;
            insert_pc   <= 1'b0;
            priv_pc     <= '0;
            intr        <= 1'b0;
            csr_we      <= 1'b0;
            mcause_w    <= '0;
            mepc_w      <= '0;
            mtval_w     <= '0;
            mie_clr     <= 1'b0;
            mie_restore <= 1'b0;
        end else begin
            // Set wins over a coincident claim.
            pend_q      <= (pend_q | ext_int) & ~(ext_claim & ~ext_int);
            insert_pc   <= 1'b0;
            csr_we      <= 1'b0;
            mie_clr     <= 1'b0;
            mie_restore <= 1'b0;
            intr        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state     <= ST_FLUSH;
                        flush_req <= 1'b1;
                        cause_q   <= req_cause;
                        intr_q    <= req_intr;
                        epc_q     <= epc;
                        mtval_q   <= mtval_zero ? '0 : badaddr;
                    end else if (ret) begin
                        state       <= ST_RET;
                        insert_pc   <= 1'b1;
                        mie_restore <= 1'b1;
                        priv_pc     <= mepc_r;
                    end
                end
                ST_FLUSH: begin
                    if (pipe_clear) begin
                        state     <= ST_TRAP;
                        flush_req <= 1'b0;
                        insert_pc <= 1'b1;
                        csr_we    <= 1'b1;
                        mie_clr   <= 1'b1;
                        intr      <= intr_q;
                        priv_pc   <= trap_target;
                        mcause_w  <= {intr_q, {(XLEN-1-CAUSE_W){1'b0}}, cause_q};
                        mepc_w    <= epc_q;
                        mtval_w   <= mtval_q;
                    end
                end
                ST_TRAP: state <= ST_IDLE;
                ST_RET:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
